// File: rtl/uart_rx.sv
// uart_rx -- receive half of the UART.
//
// The serial line is oversampled at 16x the selected baud rate. Each frame is
// a start bit, 8 data bits LSB first, an optional parity bit and one stop bit.
// The received byte and its error flags are presented with a one-cycle done
// pulse and held until the next completed frame.
//
// Parameters
//   CLK_HZ       system clock frequency in Hz
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_in        serial line, idles high, asynchronous to clk
//   baud_rate    00=2400, 01=4800, 10=9600, 11=19200 baud
//   parity_type  00=none, 01=odd, 10=even, 11=none
//   data_out     last received byte
//   rx_done      one-cycle pulse when a frame completes
//   parity_err   parity mismatch in the last frame (0 when parity is off)
//   frame_err    stop bit of the last frame sampled low
//   rx_active    high while a frame is being received
module uart_rx #(
  parameter int unsigned CLK_HZ = 1_843_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_active
);

  // Clocks per 16x oversampling tick for each baud rate.
  localparam int unsigned DIV_2400  = CLK_HZ / (2400  * 16);
  localparam int unsigned DIV_4800  = CLK_HZ / (4800  * 16);
  localparam int unsigned DIV_9600  = CLK_HZ / (9600  * 16);
  localparam int unsigned DIV_19200 = CLK_HZ / (19200 * 16);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Registers
  logic [1:0]  r_sync;
  state_t      r_state;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_sample;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [1:0]  r_baud;
  logic [1:0]  r_parity;
  logic        r_perr_pend;
  logic [7:0]  r_data;
  logic        r_perr;
  logic        r_ferr;
  logic        r_done;

  // Next-state values
  state_t      w_state_next;
  logic [15:0] w_div_cnt_next;
  logic [3:0]  w_sample_next;
  logic [2:0]  w_bit_next;
  logic [7:0]  w_shift_next;
  logic [1:0]  w_baud_next;
  logic [1:0]  w_parity_next;
  logic        w_perr_pend_next;
  logic [7:0]  w_data_next;
  logic        w_perr_next;
  logic        w_ferr_next;
  logic        w_done_next;

  logic        w_rxs;
  logic        w_par_en;
  logic [15:0] w_div_m1;
  logic        w_tick;
  logic        w_bit_end;

  assign w_rxs    = r_sync[1];
  assign w_par_en = (r_parity == 2'b01) || (r_parity == 2'b10);

  // Baud selection uses the value latched at the start edge, so a change on
  // baud_rate mid-frame has no effect until the next frame.
  always_comb begin
    w_div_m1 = 16'(DIV_9600 - 1);
    case (r_baud)
      2'b00: w_div_m1 = 16'(DIV_2400  - 1);
      2'b01: w_div_m1 = 16'(DIV_4800  - 1);
      2'b10: w_div_m1 = 16'(DIV_9600  - 1);
      2'b11: w_div_m1 = 16'(DIV_19200 - 1);
      default: w_div_m1 = 16'(DIV_9600 - 1);
    endcase
  end

  // The divider is held at 0 in IDLE so the first tick lands DIV clocks after
  // the start edge was seen.
  assign w_tick    = (r_state != S_IDLE) && (r_div_cnt == w_div_m1);
  // Last tick of a 16-tick bit period (sample counter wraps 15 -> 0).
  assign w_bit_end = w_tick && (r_sample == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= 2'b11;
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_sample    <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_baud      <= '0;
      r_parity    <= '0;
      r_perr_pend <= 1'b0;
      r_data      <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], rx_in};
      r_state     <= w_state_next;
      r_div_cnt   <= w_div_cnt_next;
      r_sample    <= w_sample_next;
      r_bit       <= w_bit_next;
      r_shift     <= w_shift_next;
      r_baud      <= w_baud_next;
      r_parity    <= w_parity_next;
      r_perr_pend <= w_perr_pend_next;
      r_data      <= w_data_next;
      r_perr      <= w_perr_next;
      r_ferr      <= w_ferr_next;
      r_done      <= w_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_div_cnt_next   = r_div_cnt;
    w_sample_next    = r_sample;
    w_bit_next       = r_bit;
    w_shift_next     = r_shift;
    w_baud_next      = r_baud;
    w_parity_next    = r_parity;
    w_perr_pend_next = r_perr_pend;
    w_data_next      = r_data;
    w_perr_next      = r_perr;
    w_ferr_next      = r_ferr;
    w_done_next      = 1'b0;

    if (r_state == S_IDLE) begin
      w_div_cnt_next = '0;
    end else if (w_tick) begin
      w_div_cnt_next = '0;
    end else begin
      w_div_cnt_next = r_div_cnt + 16'd1;
    end

    if (w_tick) begin
      w_sample_next = r_sample + 4'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_next     = S_START;
          w_sample_next    = '0;
          w_bit_next       = '0;
          w_baud_next      = baud_rate;
          w_parity_next    = parity_type;
          w_perr_pend_next = 1'b0;
        end
      end

      S_START: begin
        // Seventh tick after the edge is mid start bit.
        if (w_tick && (r_sample == 4'd6)) begin
          if (w_rxs) begin
            w_state_next = S_IDLE;
          end else begin
            w_sample_next = '0;
            w_state_next  = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = {w_rxs, r_shift[7:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_next = w_par_en ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          if (r_parity == 2'b10) begin
            w_perr_pend_next = (^r_shift) != w_rxs;
          end else begin
            w_perr_pend_next = (~^r_shift) != w_rxs;
          end
          w_state_next = S_STOP;
        end
      end

      S_STOP: begin
        // Leaving at mid-stop keeps the following start edge visible to IDLE
        // for back-to-back frames.
        if (w_bit_end) begin
          w_data_next  = r_shift;
          w_perr_next  = r_perr_pend;
          w_ferr_next  = !w_rxs;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign data_out   = r_data;
  assign rx_done    = r_done;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign rx_active  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1_843_200;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_active;

  uart_rx #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .baud_rate  (baud_rate),
    .parity_type(parity_type),
    .data_out   (data_out),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_active  (rx_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int div_of(input logic [1:0] b);
    int baud;
    baud = 2400 << b;
    return CLK_HZ / (baud * 16);
  endfunction

  function automatic bit par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  // Parity bit a correct transmitter would send.
  function automatic logic good_pbit(input logic [1:0] p, input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (p == 2'b10) return logic'(ones % 2);
    return logic'(1 - (ones % 2));
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t0;   // cycle of the start edge, -1 if not timed
    int         lat;  // nominal latency in clk
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  // ---------------- output monitor ----------------
  logic prev_done = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rx_done) begin
      done_q.push_back(cyc);
      check_eq("done_width", prev_done, 0);
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("data_out", data_out, e.d);
        check_eq("parity_err", parity_err, e.pe);
        check_eq("frame_err", frame_err, e.fe);
        if (e.t0 >= 0) begin
          check_eq("latency_in_range",
                   ((cyc - e.t0) >= e.lat - 2) && ((cyc - e.t0) <= e.lat + 2), 1);
        end
      end
    end
    prev_done = rx_done;
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input logic [7:0] d, input logic [1:0] baud, input logic [1:0] par,
                            input logic pbit, input logic stopb, input int gap_bits);
    int   bt;
    int   dv;
    exp_t x;
    dv = div_of(baud);
    bt = 16 * dv;
    baud_rate   = baud;
    parity_type = par;
    x.d   = d;
    x.pe  = par_on(par) ? (pbit != good_pbit(par, d)) : 1'b0;
    x.fe  = !stopb;
    x.t0  = cyc;
    x.lat = 2 + dv * (7 + 16 * (9 + (par_on(par) ? 1 : 0)));
    exp_q.push_back(x);
    rx_in = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (bt / 2) @(negedge clk);
      if (i == 2) check_eq("rx_active_mid", rx_active, 1);
      repeat (bt - bt / 2) @(negedge clk);
    end
    if (par_on(par)) begin
      rx_in = pbit;
      repeat (bt) @(negedge clk);
    end
    rx_in = stopb;
    repeat (bt) @(negedge clk);
    rx_in = 1'b1;
    if (!stopb) begin
      // A low stop bit still looks like a start edge when the receiver
      // returns to idle, so an all-ones frame follows from the idle line.
      x.d   = 8'hFF;
      x.pe  = par_on(par) ? (1'b1 != good_pbit(par, 8'hFF)) : 1'b0;
      x.fe  = 1'b0;
      x.t0  = -1;
      exp_q.push_back(x);
      repeat (12 * bt) @(negedge clk);
    end
    repeat (gap_bits * bt) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rb;
    logic [1:0] rp;
    logic [7:0] part;
    int         bt;

    rst         = 1'b1;
    rx_in       = 1'b1;
    baud_rate   = 2'b10;
    parity_type = 2'b00;
    repeat (4) @(negedge clk);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_rx_done", rx_done, 0);
    check_eq("rst_parity_err", parity_err, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_rx_active", rx_active, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 9600, no parity
    send_frame(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1, 1);
    // 19200, even parity: good then bad parity bit
    send_frame(8'h03, 2'b11, 2'b10, 1'b0, 1'b1, 1);
    send_frame(8'h03, 2'b11, 2'b10, 1'b1, 1'b1, 1);
    // 2400, odd parity; then low stop bit
    send_frame(8'hFF, 2'b00, 2'b01, 1'b1, 1'b1, 1);
    send_frame(8'h00, 2'b00, 2'b01, 1'b1, 1'b0, 1);

    // glitch shorter than half a bit at 9600
    baud_rate   = 2'b10;
    parity_type = 2'b00;
    rx_in = 1'b0;
    repeat (3 * div_of(2'b10)) @(negedge clk);
    check_eq("glitch_active", rx_active, 1);
    rx_in = 1'b1;
    repeat (20 * div_of(2'b10)) @(negedge clk);
    check_eq("glitch_idle", rx_active, 0);
    send_frame(8'h5A, 2'b10, 2'b00, 1'b0, 1'b1, 1);

    // back-to-back at 4800
    done_q.delete();
    send_frame(8'h12, 2'b01, 2'b00, 1'b0, 1'b1, 0);
    send_frame(8'h34, 2'b01, 2'b00, 1'b0, 1'b1, 1);
    check_eq("b2b_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check_eq("b2b_spacing_ok",
               ((done_q[1] - done_q[0]) >= 3838) && ((done_q[1] - done_q[0]) <= 3842), 1);
    end

    // reset during data bit 4 at 9600
    part = 8'h5A;
    bt   = 16 * div_of(2'b10);
    baud_rate = 2'b10;
    rx_in = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = part[i];
      repeat (bt) @(negedge clk);
    end
    rx_in = part[4];
    repeat (bt / 2) @(negedge clk);
    rx_in = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_data_out", data_out, 0);
    check_eq("mid_rst_parity_err", parity_err, 0);
    check_eq("mid_rst_frame_err", frame_err, 0);
    check_eq("mid_rst_rx_active", rx_active, 0);
    check_eq("mid_rst_rx_done", rx_done, 0);
    repeat (3 * bt) @(negedge clk);
    check_eq("mid_rst_still_idle", rx_active, 0);
    send_frame(8'hC3, 2'b10, 2'b00, 1'b0, 1'b1, 1);

    // randomized frames
    for (int n = 0; n < 10; n++) begin
      rd = 8'($urandom);
      rb = 2'($urandom_range(1, 3));
      rp = 2'($urandom_range(0, 3));
      send_frame(rd, rb, rp, good_pbit(rp, rd) ^ ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 7) != 0, int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("pending_frames", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
